vgc_vram_arbiter: RTL and testbench
===================================

Name: vgc_vram_arbiter

Overview:
- Owns the single port of the 32 KB Super Hires VRAM block RAM (8192 x 32-bit words).
- Shares that port between two requesters:
  - Apple bus shadow writes to $E1:2000-$9FFF, byte-wide and bursty.
  - VGC scan-out word reads, which are periodic and deadline-bound.
- VGC reads always win. Bus writes are buffered in a small FIFO and drained into idle RAM cycles.
- Sits between the bus capture logic, the VGC and the VRAM macro in the clk_logic domain (2x pixel clock).

Parameters:
- FIFO_DEPTH, 8, write-buffer entries; power of two, 2..32.
- RAM_LAT, 1, cycles from ram_rd_o to valid ram_rdata_i; 1..4.

Ports:
- clk_logic  in  1  logic clock, 2x pixel clock.
- system_reset_n  in  1  asynchronous active-low reset.
- wr_req_i  in  1  one-cycle pulse: bus write byte into the SHR region.
- wr_addr_i  in  15  byte offset from $E1:2000.
- wr_data_i  in  8  byte to write.
- vgc_rd_i  in  1  VGC fetch strobe; high for 2 clk_logic cycles (one pixel clock).
- vgc_addr_i  in  13  VGC word address.
- vgc_data_o  out  32  last word read for the VGC; held until the next read completes.
- ram_addr_o  out  13  VRAM word address.
- ram_wdata_o  out  32  VRAM write data.
- ram_be_o  out  4  VRAM byte enables.
- ram_we_o  out  1  VRAM write strobe.
- ram_rd_o  out  1  VRAM read strobe.
- ram_rdata_i  in  32  VRAM read data.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow_o  out  1  sticky: a write was dropped since reset.
- drop_count_o  out  8  saturating count of dropped writes.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All outputs 0; FIFO empty; state IDLE; read-pending flag clear.
  - Asserting reset mid-operation abandons any in-flight read or write. No strobe is issued on the release cycle.
- Read request detection:
  - A rising edge of vgc_rd_i (vgc_rd_i=1, previous=0) captures vgc_addr_i and sets the read-pending flag.
  - The second high cycle of the strobe is ignored.
- Write path:
  - Each wr_req_i pushes {wr_addr_i[14:2], wr_addr_i[1:0], wr_data_i} into the FIFO.
  - When the FIFO is full, the push is dropped, overflow_o is set and drop_count_o increments, saturating at 255.
  - A push and a pop in the same cycle while full: the push is accepted and the level is unchanged.
- FSM states: IDLE, READ, RWAIT.
  - IDLE:
    - If read-pending: drive ram_rd_o=1 and ram_addr_o=captured address for one cycle, clear the flag, go to READ.
    - Else if FIFO not empty: pop one entry and issue a one-cycle write, staying in IDLE.
    - Write encoding: ram_addr_o=word addr, ram_be_o=1<<byte_sel, ram_wdata_o={4{byte}}, ram_we_o=1.
  - READ: when RAM_LAT=1, capture ram_rdata_i into vgc_data_o this cycle and go to IDLE. Otherwise go to RWAIT.
  - RWAIT: count down RAM_LAT-1 cycles. Capture into vgc_data_o on the last cycle, then go to IDLE.
  - No writes are issued in READ or RWAIT. ram_rd_o and ram_we_o are never high together.
- Latency:
  - A read edge seen in IDLE gives ram_rd_o on the next cycle and vgc_data_o updated RAM_LAT+1 cycles after ram_rd_o.
  - If the edge coincides with a write issue, the read slips by one cycle.
  - Worst case is edge to data at RAM_LAT+3 cycles, which must stay ≤ 24. This holds for all legal RAM_LAT.
- A new read edge during READ/RWAIT sets the pending flag and is served immediately after. The VGC cadence (16 pixel = 32 logic cycles) guarantees no loss.
- Ordering:
  - Writes retire in FIFO order.
  - Reads are not checked against queued writes. A read may return pre-write data; this is accepted because the next frame is correct.
- Strobes are 0 and address/data/byte enables are 0 when idle. Outputs are registered.

Test Plan:
- Reset released, wr_req_i with addr 0x0005, data 0xA5 → next-but-one cycle: ram_we_o=1, ram_addr_o=1, ram_be_o=4'b0010, ram_wdata_o=0xA5A5A5A5; fifo_level_o returns to 0.
- RAM_LAT=1, vgc_rd_i high 2 cycles with addr 0x1F40, ram_rdata_i=0xDEADBEEF → exactly one ram_rd_o pulse with addr 0x1F40; vgc_data_o=0xDEADBEEF 2 cycles after the pulse, held until the next read.
- Queue 5 writes, then raise vgc_rd_i → ram_rd_o issued no later than 2 cycles after the edge, never overlapping ram_we_o; remaining writes drain afterwards in order.
- 10 back-to-back writes with vgc_rd_i toggling every cycle to starve the drain (FIFO_DEPTH=8) → fifo_level_o=8, drop_count_o=2, overflow_o=1; after 300 further drops drop_count_o=255.
- Push while full in the same cycle as a pop → level stays 8, drop_count_o unchanged.
- Assert system_reset_n low during RWAIT (RAM_LAT=3) with 4 queued writes → all outputs 0 immediately; after release no ram_we_o/ram_rd_o pulses without new requests.

Source files
------------

// File: rtl/vgc_vram_arbiter_if.sv
// Bus bundle for the Super Hires VRAM arbiter: bus-capture writes, VGC fetches,
// the VRAM macro port and the write-buffer status.
interface vgc_vram_arbiter_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_req_i;
  logic [14:0]   wr_addr_i;
  logic [7:0]    wr_data_i;
  logic          vgc_rd_i;
  logic [12:0]   vgc_addr_i;
  logic [31:0]   vgc_data_o;
  logic [12:0]   ram_addr_o;
  logic [31:0]   ram_wdata_o;
  logic [3:0]    ram_be_o;
  logic          ram_we_o;
  logic          ram_rd_o;
  logic [31:0]   ram_rdata_i;
  logic [LW-1:0] fifo_level_o;
  logic          overflow_o;
  logic [7:0]    drop_count_o;

  modport slave (
    input  wr_req_i, wr_addr_i, wr_data_i, vgc_rd_i, vgc_addr_i, ram_rdata_i,
    output vgc_data_o, ram_addr_o, ram_wdata_o, ram_be_o, ram_we_o, ram_rd_o,
           fifo_level_o, overflow_o, drop_count_o
  );

  modport master (
    output wr_req_i, wr_addr_i, wr_data_i, vgc_rd_i, vgc_addr_i, ram_rdata_i,
    input  vgc_data_o, ram_addr_o, ram_wdata_o, ram_be_o, ram_we_o, ram_rd_o,
           fifo_level_o, overflow_o, drop_count_o
  );
endinterface

// File: rtl/vgc_vram_arbiter.sv
// Single-port VRAM arbiter: VGC scan-out reads always win, bus shadow writes are
// buffered in a small FIFO and drained into idle RAM cycles.
module vgc_vram_arbiter #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned RAM_LAT    = 1
) (
  input logic               clk_logic,
  input logic               system_reset_n,
  vgc_vram_arbiter_if.slave bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 2;
  localparam logic [CW-1:0] RWAIT_INIT = (RAM_LAT > 1) ? CW'(RAM_LAT - 2) : '0;

  typedef struct packed {
    logic [12:0] word;
    logic [1:0]  sel;
    logic [7:0]  data;
  } wr_entry_t;

  typedef enum logic [1:0] {IDLE, READ, RWAIT} state_t;

  state_t          state_q, state_d;
  wr_entry_t       fifo_mem [FIFO_DEPTH];
  wr_entry_t       head;
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [LW-1:0]   level_q;
  logic            vgc_rd_prev_q, rd_pend_q;
  logic [12:0]     rd_addr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cap_q, cap_d;
  logic            rd_edge, fifo_full, fifo_empty, pop, push, drop, rd_issue;
  logic [12:0]     addr_d, ram_addr_q;
  logic [31:0]     wdata_d, ram_wdata_q, vgc_data_q;
  logic [3:0]      be_d, ram_be_q;
  logic            we_d, rd_d, ram_we_q, ram_rd_q, overflow_q;
  logic [7:0]      drop_count_q;

  assign rd_edge    = bus.vgc_rd_i & ~vgc_rd_prev_q;
  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign head       = fifo_mem[rptr_q];
  // A full FIFO still accepts a push when the same cycle pops an entry.
  assign push       = bus.wr_req_i & (~fifo_full | pop);
  assign drop       = bus.wr_req_i & fifo_full & ~pop;

  // Next-state and next-output logic; reads take priority over queued writes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_d    = 1'b0;
    pop      = 1'b0;
    rd_issue = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;
    be_d     = '0;
    we_d     = 1'b0;
    rd_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_pend_q) begin
          rd_d     = 1'b1;
          addr_d   = rd_addr_q;
          rd_issue = 1'b1;
          state_d  = READ;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          we_d    = 1'b1;
          addr_d  = head.word;
          be_d    = 4'b0001 << head.sel;
          wdata_d = {4{head.data}};
        end
      end
      READ: begin
        if (RAM_LAT == 1) begin
          cap_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = RWAIT_INIT;
          state_d = RWAIT;
        end
      end
      RWAIT: begin
        if (cnt_q == '0) begin
          cap_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_logic) begin
    if (push) fifo_mem[wptr_q] <= '{word: bus.wr_addr_i[14:2], sel: bus.wr_addr_i[1:0],
                                    data: bus.wr_data_i};
  end

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cap_q         <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      level_q       <= '0;
      vgc_rd_prev_q <= 1'b0;
      rd_pend_q     <= 1'b0;
      rd_addr_q     <= '0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      ram_be_q      <= '0;
      ram_we_q      <= 1'b0;
      ram_rd_q      <= 1'b0;
      vgc_data_q    <= '0;
      overflow_q    <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cap_q         <= cap_d;
      vgc_rd_prev_q <= bus.vgc_rd_i;
      ram_addr_q    <= addr_d;
      ram_wdata_q   <= wdata_d;
      ram_be_q      <= be_d;
      ram_we_q      <= we_d;
      ram_rd_q      <= rd_d;
      // A new edge re-arms the flag even in the cycle the previous read issues.
      if (rd_edge) begin
        rd_pend_q <= 1'b1;
        rd_addr_q <= bus.vgc_addr_i;
      end else if (rd_issue) begin
        rd_pend_q <= 1'b0;
      end
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);
      if (cap_q) vgc_data_q <= bus.ram_rdata_i;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
      end
    end
  end

  assign bus.ram_addr_o   = ram_addr_q;
  assign bus.ram_wdata_o  = ram_wdata_q;
  assign bus.ram_be_o     = ram_be_q;
  assign bus.ram_we_o     = ram_we_q;
  assign bus.ram_rd_o     = ram_rd_q;
  assign bus.vgc_data_o   = vgc_data_q;
  assign bus.fifo_level_o = level_q;
  assign bus.overflow_o   = overflow_q;
  assign bus.drop_count_o = drop_count_q;
endmodule

// File: tb/tb_vgc_vram_arbiter.sv
// Directed bench for vgc_vram_arbiter: one instance at RAM_LAT=1, one at RAM_LAT=3,
// each backed by a latency-accurate VRAM read model.
module tb_vgc_vram_arbiter;
  logic clk;
  logic rst_n;
  logic rst3_n;
  int   checks   = 0;
  int   failures = 0;
  bit   overlap_seen = 1'b0;

  vgc_vram_arbiter_if #(.FIFO_DEPTH(8)) bus1 ();
  vgc_vram_arbiter_if #(.FIFO_DEPTH(8)) bus3 ();

  vgc_vram_arbiter #(.FIFO_DEPTH(8), .RAM_LAT(1)) dut (
    .clk_logic(clk), .system_reset_n(rst_n), .bus(bus1)
  );
  vgc_vram_arbiter #(.FIFO_DEPTH(8), .RAM_LAT(3)) dut3 (
    .clk_logic(clk), .system_reset_n(rst3_n), .bus(bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [12:0] a);
    if (a == 13'h1F40) return 32'hDEAD_BEEF;
    if (a == 13'h0010) return 32'hCAFE_F00D;
    return {19'h0ABCD, a};
  endfunction

  // VRAM read models; data is garbage except RAM_LAT cycles after a read strobe.
  logic [31:0] p1;
  logic [31:0] p3 [3];
  always @(posedge clk) begin
    p1    <= bus1.ram_rd_o ? ram_word(bus1.ram_addr_o) : 32'hBAD0_BAD0;
    p3[0] <= bus3.ram_rd_o ? ram_word(bus3.ram_addr_o) : 32'hBAD3_BAD3;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus1.ram_rdata_i = p1;
  assign bus3.ram_rdata_i = p3[2];

  always @(negedge clk) begin
    if ((bus1.ram_rd_o && bus1.ram_we_o) || (bus3.ram_rd_o && bus3.ram_we_o)) overlap_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [12:0] exp_words [5];
  logic [12:0] seen_words [$];
  int          rd_cycle;
  int          rd_count;
  int          pulses;

  initial begin
    rst_n = 1'b0; rst3_n = 1'b0;
    bus1.wr_req_i = 1'b0; bus1.wr_addr_i = '0; bus1.wr_data_i = '0;
    bus1.vgc_rd_i = 1'b0; bus1.vgc_addr_i = '0;
    bus3.wr_req_i = 1'b0; bus3.wr_addr_i = '0; bus3.wr_data_i = '0;
    bus3.vgc_rd_i = 1'b0; bus3.vgc_addr_i = '0;
    step(); step();

    // Reset state
    check("rst_vgc_data", 64'(bus1.vgc_data_o), 64'h0);
    check("rst_ram_bus", 64'({bus1.ram_addr_o, bus1.ram_wdata_o, bus1.ram_be_o}), 64'h0);
    check("rst_strobes", 64'({bus1.ram_we_o, bus1.ram_rd_o}), 64'h0);
    check("rst_status", 64'({bus1.fifo_level_o, bus1.overflow_o, bus1.drop_count_o}), 64'h0);
    rst_n = 1'b1; rst3_n = 1'b1;
    step();
    check("release_no_strobe", 64'({bus1.ram_we_o, bus1.ram_rd_o, bus3.ram_we_o, bus3.ram_rd_o}), 64'h0);

    // Single write: byte 0x0005 -> word 1, lane 1
    bus1.wr_req_i = 1'b1; bus1.wr_addr_i = 15'h0005; bus1.wr_data_i = 8'hA5;
    step();
    check("t1_level_push", 64'(bus1.fifo_level_o), 64'd1);
    check("t1_no_we_yet", 64'(bus1.ram_we_o), 64'd0);
    bus1.wr_req_i = 1'b0;
    step();
    check("t1_we", 64'(bus1.ram_we_o), 64'd1);
    check("t1_addr", 64'(bus1.ram_addr_o), 64'd1);
    check("t1_be", 64'(bus1.ram_be_o), 64'b0010);
    check("t1_wdata", 64'(bus1.ram_wdata_o), 64'hA5A5_A5A5);
    check("t1_level_drain", 64'(bus1.fifo_level_o), 64'd0);
    step();
    check("t1_idle_zero", 64'({bus1.ram_we_o, bus1.ram_addr_o, bus1.ram_be_o, bus1.ram_wdata_o}), 64'h0);

    // Single VGC read, strobe held for two cycles
    bus1.vgc_rd_i = 1'b1; bus1.vgc_addr_i = 13'h1F40;
    step();
    check("t2_rd_not_yet", 64'(bus1.ram_rd_o), 64'd0);
    step();
    check("t2_rd_pulse", 64'({bus1.ram_rd_o, bus1.ram_we_o}), 64'b10);
    check("t2_rd_addr", 64'(bus1.ram_addr_o), 64'h1F40);
    bus1.vgc_rd_i = 1'b0;
    step();
    check("t2_one_pulse", 64'(bus1.ram_rd_o), 64'd0);
    check("t2_data_not_yet", 64'(bus1.vgc_data_o), 64'h0);
    step();
    check("t2_data", 64'(bus1.vgc_data_o), 64'hDEAD_BEEF);
    repeat (5) step();
    check("t2_data_held", 64'(bus1.vgc_data_o), 64'hDEAD_BEEF);

    // Five writes with a read edge arriving mid-drain
    exp_words = '{13'h040, 13'h041, 13'h042, 13'h043, 13'h045};
    rd_cycle = -1; rd_count = 0;
    for (int n = 0; n < 14; n++) begin
      bus1.wr_req_i  = (n < 5);
      bus1.wr_addr_i = 15'h0100 + 15'(n * 5);
      bus1.wr_data_i = 8'(8'h30 + n);
      bus1.vgc_rd_i  = (n == 2 || n == 3);
      bus1.vgc_addr_i = 13'h0777;
      step();
      if (bus1.ram_we_o) seen_words.push_back(bus1.ram_addr_o);
      if (bus1.ram_rd_o) begin
        rd_count++;
        if (rd_cycle < 0) rd_cycle = n;
      end
    end
    check("t3_rd_count", 64'(rd_count), 64'd1);
    check("t3_rd_latency", 64'(rd_cycle >= 3 && rd_cycle <= 4), 64'd1);
    check("t3_write_count", 64'(seen_words.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < seen_words.size()) check($sformatf("t3_order%0d", k), 64'(seen_words[k]), 64'(exp_words[k]));
    end
    check("t3_rd_data", 64'(bus1.vgc_data_o), 64'(ram_word(13'h0777)));

    // Starve the drain with a read edge every other cycle and overfill
    for (int i = 0; i <= 330; i++) begin
      bus1.vgc_rd_i   = ((i <= 14) || (i >= 18)) && (i % 2 == 0);
      bus1.wr_req_i   = (i >= 4 && i <= 13) || (i >= 17);
      bus1.wr_addr_i  = 15'(i);
      bus1.wr_data_i  = 8'(i);
      step();
      if (i == 13) begin
        check("t4_level_full", 64'(bus1.fifo_level_o), 64'd8);
        check("t4_drop2", 64'(bus1.drop_count_o), 64'd2);
        check("t4_overflow", 64'(bus1.overflow_o), 64'd1);
      end
      if (i == 17) begin
        check("t5_level_pushpop", 64'(bus1.fifo_level_o), 64'd8);
        check("t5_drop_unchanged", 64'(bus1.drop_count_o), 64'd2);
        check("t5_pop_write", 64'({bus1.ram_we_o, bus1.ram_addr_o, bus1.ram_be_o}),
              64'({1'b1, 13'd1, 4'b0001}));
        check("t5_pop_wdata", 64'(bus1.ram_wdata_o), 64'h0404_0404);
      end
      if (i == 270) check("t4_drop254", 64'(bus1.drop_count_o), 64'd254);
      if (i == 271) check("t4_drop255", 64'(bus1.drop_count_o), 64'd255);
    end
    check("t4_drop_saturated", 64'(bus1.drop_count_o), 64'd255);
    check("t4_level_end", 64'(bus1.fifo_level_o), 64'd8);
    bus1.wr_req_i = 1'b0; bus1.vgc_rd_i = 1'b0;
    repeat (20) step();
    check("t4_drained", 64'(bus1.fifo_level_o), 64'd0);
    check("t4_overflow_sticky", 64'(bus1.overflow_o), 64'd1);

    // RAM_LAT=3 read latency
    bus3.vgc_rd_i = 1'b1; bus3.vgc_addr_i = 13'h0010;
    step(); step();
    check("t6_rd3_pulse", 64'({bus3.ram_rd_o, bus3.ram_addr_o}), 64'({1'b1, 13'h0010}));
    bus3.vgc_rd_i = 1'b0;
    step(); step(); step();
    check("t6_data3_not_yet", 64'(bus3.vgc_data_o), 64'h0);
    step();
    check("t6_data3", 64'(bus3.vgc_data_o), 64'hCAFE_F00D);
    repeat (3) step();

    // Reset during RWAIT with four queued writes
    for (int k = 0; k < 4; k++) begin
      bus3.vgc_rd_i = (k < 2); bus3.vgc_addr_i = 13'h0020;
      bus3.wr_req_i = 1'b1; bus3.wr_addr_i = 15'(k * 4); bus3.wr_data_i = 8'(8'h70 + k);
      step();
    end
    check("t7_level_pre_reset", 64'(bus3.fifo_level_o), 64'd4);
    bus3.wr_req_i = 1'b0; bus3.vgc_rd_i = 1'b0;
    rst3_n = 1'b0;
    #1;
    check("t7_rst_data", 64'(bus3.vgc_data_o), 64'h0);
    check("t7_rst_status", 64'({bus3.fifo_level_o, bus3.overflow_o, bus3.drop_count_o}), 64'h0);
    check("t7_rst_ram", 64'({bus3.ram_we_o, bus3.ram_rd_o, bus3.ram_addr_o, bus3.ram_be_o, bus3.ram_wdata_o}), 64'h0);
    step(); step();
    rst3_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus3.ram_we_o || bus3.ram_rd_o) pulses++;
    end
    check("t7_no_pulses", 64'(pulses), 64'd0);
    check("t7_data_stays0", 64'(bus3.vgc_data_o), 64'h0);
    check("no_rd_we_overlap", 64'(overlap_seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
